// File: rtl/lifo_pkg.sv
// Shared defaults and state type for the lifo read-side drain logic.
package lifo_pkg;

    localparam int unsigned DWIDTH_DEF = 16;
    localparam int unsigned AWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry registered stream buffer: write port in, valid/ready/data out.
// The writer is responsible for never writing into a full buffer that is not popping.
module stream_skid_buf #(
    parameter int unsigned DWIDTH = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              valid,
    input  logic              ready,
    output logic [DWIDTH-1:0] data,
    output logic [1:0]        occ
);

    logic [DWIDTH-1:0] mem [2];
    logic              head;
    logic              pop;
    logic              wr_idx;

    assign pop    = valid && ready;
    // With two entries the tail slot is head when occ is 0 or 2, the other slot when occ is 1.
    assign wr_idx = head ^ occ[0];
    assign valid  = (occ != 2'd0);
    assign data   = valid ? mem[head] : '0;

    always_ff @(posedge clk) begin
        if (srst) begin
            occ  <= 2'd0;
            head <= 1'b0;
        end else begin
            if (pop) begin
                head <= ~head;
            end
            occ <= occ + 2'(wr_en) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && wr_en && !pop) begin
            assert (occ != 2'd2);
        end
    end

endmodule

// File: rtl/lifo_drain_streamer.sv
// Pops the current lifo contents and re-emits them as one valid/ready packet with last.
module lifo_drain_streamer
    import lifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned AWIDTH = AWIDTH_DEF
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              lifo_rdreq_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);

    localparam int unsigned CW = AWIDTH + 1;

    drain_state_t  state;
    drain_state_t  state_next;
    logic [CW-1:0] rem_req;
    logic [CW-1:0] rem_out;
    logic          inflight;
    logic          rdreq_c;
    logic          pop;
    logic [1:0]    occ;
    logic [2:0]    credit_used;
    logic [2:0]    credit_limit;

    stream_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk     (clk_i),
        .srst    (srst_i),
        .wr_en   (inflight),
        .wr_data (lifo_q_i),
        .valid   (valid_o),
        .ready   (ready_i),
        .data    (data_o),
        .occ     (occ)
    );

    assign pop          = valid_o && ready_i;
    assign last_o       = valid_o && (rem_out == CW'(1));
    assign lifo_rdreq_o = rdreq_c;

    // Buffered plus in-flight words, less this cycle's pop, must stay below the buffer depth.
    assign credit_used  = 3'(occ) + 3'(inflight);
    assign credit_limit = 3'd2 + 3'(pop);

    always_comb begin
        state_next = state;
        rdreq_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !lifo_empty_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                rdreq_c = (rem_req != '0) && !lifo_empty_i && (credit_used < credit_limit);
                if (pop && last_o) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= IDLE;
            rem_req  <= '0;
            rem_out  <= '0;
            inflight <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= rdreq_c;
            busy_o   <= (state_next != IDLE);
            done_o   <= (state_next == DONE);
            if (state == IDLE && state_next == DRAIN) begin
                rem_req <= lifo_usedw_i;
                rem_out <= lifo_usedw_i;
            end else begin
                if (rdreq_c) begin
                    rem_req <= rem_req - CW'(1);
                end
                if (pop) begin
                    rem_out <= rem_out - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lifo_drain_streamer.sv
// Randomized bench for lifo_drain_streamer with a stack-model lifo and a packet-level reference.
module tb_lifo_drain_streamer;

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic        busy;
    logic        done;
    logic        rdreq;
    logic [15:0] q;
    logic        empty;
    logic [8:0]  usedw;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        last;

    logic        push_en;
    logic [15:0] push_data;
    logic [15:0] mem [256];
    int          l_used;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    lifo_drain_streamer #(.DWIDTH(16), .AWIDTH(8)) u_dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .lifo_rdreq_o (rdreq),
        .lifo_q_i     (q),
        .lifo_empty_i (empty),
        .lifo_usedw_i (usedw),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .last_o       (last)
    );

    // Stack model of the lifo: one-cycle registered read data.
    assign empty = (l_used == 0);
    assign usedw = 9'(l_used);

    initial l_used = 0;
    always @(posedge clk) begin
        if (rdreq && l_used > 0) begin
            q      <= mem[l_used-1];
            l_used <= l_used - 1;
        end else if (push_en && l_used < 256) begin
            mem[l_used] <= push_data;
            l_used      <= l_used + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: an accepted start snapshots the stack top-down as the expected packet.
    int          m_busy = 0;
    int          m_done = 0;
    logic [15:0] exp_q [$];
    int          idx    = 0;
    int          rd_cnt = 0;
    bit          p_valid, p_stall, p_srst;
    logic [15:0] p_data;

    always @(negedge clk) begin
        if (mon_en) begin
            bit hs;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            if (m_busy == 0) begin
                chk("idle_valid", 32'(valid), 32'd0);
                chk("idle_rdreq", 32'(rdreq), 32'd0);
            end
            if (rdreq) begin
                rd_cnt++;
                chk("rdreq_when_empty", 32'(empty), 32'd0);
            end
            if (p_valid && p_stall && !p_srst) begin
                chk("stall_valid", 32'(valid), 32'd1);
                chk("stall_data", 32'(data), 32'(p_data));
            end
            hs = valid && ready;
            if (hs) begin
                if (idx < exp_q.size()) begin
                    chk("data", 32'(data), 32'(exp_q[idx]));
                    chk("last", 32'(last), 32'(idx == exp_q.size() - 1));
                end else begin
                    chk("extra_word", 32'(idx), 32'(exp_q.size()));
                end
                idx++;
            end
            if (srst) begin
                m_busy = 0;
                m_done = 0;
                exp_q.delete();
                idx = 0;
            end else if (m_done != 0) begin
                chk("rdreq_total", 32'(rd_cnt), 32'(exp_q.size()));
                m_done = 0;
                m_busy = 0;
            end else if (hs && idx == exp_q.size()) begin
                m_done = 1;
            end else if (m_busy == 0 && start && l_used != 0) begin
                m_busy = 1;
                exp_q.delete();
                for (int i = l_used - 1; i >= 0; i--) exp_q.push_back(mem[i]);
                idx    = 0;
                rd_cnt = 0;
            end
            p_valid = valid;
            p_stall = !ready;
            p_srst  = srst;
            p_data  = data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        push_en   = 1'b1;
        push_data = w;
        step();
        push_en   = 1'b0;
    endtask

    // Runs until done_o or the cycle budget expires, with ready random or held high.
    task automatic wait_done(input string name, input int budget, input bit rnd);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) seen = 1'b1;
            step();
            start = 1'b0;
        end
        chk(name, 32'(seen), 32'd1);
        ready = 1'b1;
    endtask

    initial begin
        logic [15:0] basic_exp [4];
        int first, run, hs_n, done_n;
        basic_exp = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
        srst = 1'b1; start = 1'b0; ready = 1'b1; push_en = 1'b0; push_data = '0;
        step(); step();
        srst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdreq", 32'(rdreq), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        step();
        mon_en = 1'b1;

        // Basic drain with cycle-exact literal expectations.
        for (int i = 1; i <= 4; i++) push(16'(i));
        start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 1) chk("basic_rdreq_c1", 32'(rdreq), 32'd1);
            if (c == 2) chk("basic_valid_c2", 32'(valid), 32'd0);
            if (c >= 3 && c <= 6) begin
                chk("basic_valid", 32'(valid), 32'd1);
                chk("basic_data", 32'(data), 32'(basic_exp[c-3]));
                chk("basic_last", 32'(last), 32'(c == 6));
            end
            chk("basic_done", 32'(done), 32'(c == 7));
            step();
            start = 1'b0;
        end
        chk("basic_lifo_empty", 32'(l_used), 32'd0);

        // Backpressure with random ready.
        for (int i = 0; i < 4; i++) push(16'($urandom));
        start = 1'b1;
        wait_done("bp_done_seen", 200, 1'b1);
        chk("bp_lifo_empty", 32'(l_used), 32'd0);

        // Full drain: 256 words back-to-back starting in cycle 3.
        for (int i = 0; i < 256; i++) push(16'($urandom));
        start = 1'b1;
        first = -1; run = 0;
        for (int c = 0; c < 270; c++) begin
            @(negedge clk);
            if (valid) begin
                if (first < 0) first = c;
                if (c == first + run) run++;
            end
            step();
            start = 1'b0;
        end
        chk("full_first_cycle", 32'(first), 32'd3);
        chk("full_run", 32'(run), 32'd256);
        chk("full_lifo_empty", 32'(l_used), 32'd0);

        // Start with empty lifo is ignored.
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("empty_busy", 32'(busy), 32'd0);
            chk("empty_done", 32'(done), 32'd0);
            chk("empty_rdreq", 32'(rdreq), 32'd0);
            step();
            start = 1'b0;
        end

        // Second start during a drain is ignored.
        for (int i = 0; i < 4; i++) push(16'($urandom));
        start = 1'b1;
        hs_n = 0; done_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid && ready) hs_n++;
            if (done) done_n++;
            step();
            start = (c == 1);
        end
        chk("mid_start_words", 32'(hs_n), 32'd4);
        chk("mid_start_dones", 32'(done_n), 32'd1);

        // Reset mid-drain, then drain the remainder.
        for (int i = 0; i < 8; i++) push(16'($urandom));
        start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            srst = (c == 5);
            @(negedge clk);
            if (c == 6) begin
                chk("rst_mid_valid", 32'(valid), 32'd0);
                chk("rst_mid_busy", 32'(busy), 32'd0);
                chk("rst_mid_rdreq", 32'(rdreq), 32'd0);
            end
            step();
            start = 1'b0;
        end
        srst = 1'b0;
        chk("rst_mid_remaining", 32'(l_used), 32'd3);
        step();
        start = 1'b1;
        wait_done("rst_restart_done", 200, 1'b1);
        chk("rst_restart_empty", 32'(l_used), 32'd0);

        // Single word: valid and last together in cycle 3, done in cycle 4.
        push(16'hBEEF);
        start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("single_valid", 32'(valid), 32'd1);
                chk("single_last", 32'(last), 32'd1);
                chk("single_data", 32'(data), 32'h0000BEEF);
            end
            chk("single_done", 32'(done), 32'(c == 4));
            step();
            start = 1'b0;
        end

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lifo_drain_streamer.md
Name: lifo_drain_streamer

Overview:
- Read-side master for the lifo block. On a start request it pops the LIFO's current contents through the lifo read port (rdreq/q, 1-cycle read latency).
- It re-emits those words as one valid/ready stream packet, marking the final word with last_o.
- It sits between a lifo instance and any downstream stream consumer. It provides order reversal of a buffered burst without exposing rdreq timing downstream.

Parameters:
- DWIDTH, 16, data word width; must match the lifo DWIDTH.
- AWIDTH, 8, lifo address width; the lifo depth is 2**AWIDTH and usedw is AWIDTH+1 bits.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- start_i  in  1  single-cycle request to drain the current LIFO contents as one packet.
- busy_o  out  1  high from accepted start until done_o; the upstream writer must not assert lifo wrreq while busy_o is high.
- done_o  out  1  one-cycle pulse after the last word's handshake.
- lifo_rdreq_o  out  1  lifo read request.
- lifo_q_i  in  DWIDTH  lifo read data, valid the cycle after lifo_rdreq_o.
- lifo_empty_i  in  1  lifo empty flag.
- lifo_usedw_i  in  AWIDTH+1  lifo occupancy.
- data_o  out  DWIDTH  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready; a handshake occurs when valid_o && ready_i.
- last_o  out  1  final word of the packet; qualified by valid_o.

Behaviour:
- Reset: all outputs are 0. State is IDLE, counters are 0, the output buffer is emptied, and any in-flight read is discarded. srst_i has priority in any state, including mid-DRAIN. Words already popped but not yet delivered are lost; the bench accounts for this.
- FSM states are IDLE, DRAIN and DONE.
- IDLE -> DRAIN when start_i=1 and lifo_empty_i=0.
  - rem_req is latched to lifo_usedw_i; rem_out is latched to lifo_usedw_i.
  - busy_o=1 from the next cycle.
- start_i in IDLE with lifo_empty_i=1 is ignored: no busy_o, no done_o.
- start_i while busy_o=1 is ignored.
- Read issue in DRAIN:
  - lifo_rdreq_o = (rem_req != 0) && (occ + inflight - pop) < 2.
  - occ is the output buffer count (0..2), inflight is the registered rdreq of the previous cycle, and pop = valid_o && ready_i.
  - Each issued rdreq decrements rem_req.
  - lifo_rdreq_o is never high when lifo_empty_i=1 or outside DRAIN.
- Capture: when inflight=1, lifo_q_i is written into the 2-entry output buffer at that clock edge. The write path has no overflow by construction; an overflow is an assertion failure.
- Output: data_o/valid_o come from the head of the buffer, registered. valid_o stays high until the handshake, and data_o stays stable while valid_o && !ready_i.
- last_o = valid_o && (rem_out == 1). Each handshake decrements rem_out.
- Latency and throughput:
  - start_i in cycle 0 gives rdreq in cycle 1, q in cycle 2, and valid_o in cycle 3.
  - With ready_i held high, one word per cycle is delivered, with no bubbles after the first.
- DRAIN -> DONE on the handshake with last_o=1. DONE lasts 1 cycle with done_o=1 and busy_o=1, then returns to IDLE with busy_o=0.
- Widths: rem_req and rem_out are AWIDTH+1 bits, so a full drain of 2**AWIDTH words is supported. There is no wrap-around.
- Words pushed during busy_o violate the protocol; the behaviour is undefined, but the FSM must still terminate after rem_out handshakes.

Decomposition:
- Package lifo_pkg holds the default DWIDTH/AWIDTH localparams and typedef enum logic [1:0] {IDLE, DRAIN, DONE} drain_state_t.
- One sub-module: stream_skid_buf (2-entry buffer with wr_en/wr_data in and valid/ready/data out, exposing occ). It is reusable by other stream blocks.
- The FSM, counters and rdreq credit logic live in lifo_drain_streamer.

Test Plan:
- Basic drain: push 0x0001..0x0004, start_i with ready_i=1.
  - data_o = 0x0004, 0x0003, 0x0002, 0x0001 in cycles 3..6.
  - last_o only with 0x0001; done_o in cycle 7; lifo empty afterwards.
- Backpressure: same 4 words, ready_i toggling 1/0 from a $urandom pattern.
  - Same order and no duplicates; data_o stable while stalled.
  - lifo_rdreq_o total = 4; buffer occ never exceeds 2.
- Full drain: push 256 random words (full_o=1), start_i, ready_i=1.
  - 256 words out in reverse push order, back-to-back; last_o on word 256; usedw=0 afterwards.
- Empty/ignored start:
  - start_i with lifo empty -> busy_o, done_o and lifo_rdreq_o stay 0 for 10 cycles.
  - start_i mid-DRAIN of 4 words -> still exactly 4 words and one done_o.
- Reset mid-operation: 8 words pushed, start_i, srst_i asserted in cycle 5 for 1 cycle.
  - Next cycle: valid_o=0, busy_o=0, lifo_rdreq_o=0.
  - A new start drains the remaining lifo contents (usedw at restart) correctly.
- Single word: push 0xBEEF, start_i, ready_i=1.
  - valid_o and last_o both high with 0xBEEF in cycle 3; done_o in cycle 4.
